shift_add_product_accumulator: RTL
==================================

SHIFT_ADD_PRODUCT_ACCUMULATOR -- requirements
Module: shift_add_product_accumulator

Interface
REQ-001 Parameter P_W, default 16, width of each incoming product; matches the m+n-bit product of the upstream 8x8 shift-and-add multiplier.
REQ-002 Parameter ACC_W, default 18, width of the saturating accumulator and result; ACC_W SHALL be >= P_W.
REQ-003 Parameter LEN_W, default 4, width of the block-length field.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a new accumulation block; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of products in the block, latched on accepted start; 0 means 2^LEN_W.
REQ-008 prod  input  P_W  unsigned product from the multiplier.
REQ-009 prod_valid  input  1  prod is valid this cycle.
REQ-010 prod_ready  output  1  block accepts prod this cycle.
REQ-011 sum  output  ACC_W  accumulated result.
REQ-012 sum_valid  output  1  sum is final and held.
REQ-013 sum_ready  input  1  downstream consumes sum.
REQ-014 ovf  output  1  saturation occurred in the current/last block.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ACC, DONE; all outputs registered or decoded from state only (no input-to-output combinational path).
REQ-017 IDLE: prod_ready=0, sum_valid=0, busy=0; sum and ovf hold the previous block's values.
REQ-018 IDLE with start=1: next edge latches len, clears sum to 0, clears ovf, clears accepted count, enters ACC.
REQ-019 ACC: prod_ready=1, busy=1; a transfer occurs on an edge where prod_valid=1 and prod_ready=1.
REQ-020 On each transfer, sum <= min(sum + zero-extended prod, 2^ACC_W-1); if the unclipped sum exceeds 2^ACC_W-1, ovf <= 1 (sticky until next accepted start).
REQ-021 prod_valid=0 cycles in ACC leave sum, count and ovf unchanged; gaps of any length are legal.
REQ-022 On the transfer that makes the accepted count equal the latched length, state becomes DONE on that same edge; sum_valid=1 the following cycle (latency: 1 cycle after last transfer).
REQ-023 DONE: sum_valid=1, prod_ready=0, busy=1; sum and ovf stable until handshake.
REQ-024 DONE with sum_ready=1: next edge returns to IDLE; sum_valid=0 from that cycle.
REQ-025 start is ignored in ACC and DONE, including start coincident with the DONE handshake.
REQ-026 prod_valid in IDLE or DONE is ignored; no transfer occurs.
REQ-027 Count register SHALL be LEN_W+1 bits so len=0 (2^LEN_W products) completes without wrap.
REQ-028 Saturated sum stays at 2^ACC_W-1 for remaining transfers of the block; count still advances.

Reset
REQ-029 rst=1 forces asynchronously: state IDLE, sum=0, sum_valid=0, ovf=0, prod_ready=0, busy=0, count=0, latched len=0.
REQ-030 rst asserted mid-block aborts the block; no partial sum_valid is produced after rst deassertion.
REQ-031 First start is honoured on the first rising edge with rst=0.

Verification
REQ-032 start, len=3; products 10,20,30 with one idle cycle between each -> sum_valid=1 one cycle after 3rd transfer, sum=60, ovf=0.
REQ-033 len=4, four products of 65535 -> sum=262140, ovf=0; repeat with len=5 -> sum=262143, ovf=1.
REQ-034 len=0, sixteen products of 1 -> sum=16 only after the 16th transfer; prod_ready=1 throughout the 16 transfers.
REQ-035 In DONE hold sum_ready=0 for 5 cycles while toggling prod_valid and start -> sum, ovf constant, prod_ready=0, no new block started; sum_ready=1 -> IDLE next cycle.
REQ-036 rst pulse after 2 of 3 products -> all outputs reset immediately; new block len=1, prod=7 -> sum=7, ovf=0.

Source files
------------

// File: rtl/shift_add_product_accumulator.sv
// Saturating accumulator for a block of unsigned products.
// A block starts on an accepted start, sums len products (0 means 2^LEN_W),
// then holds the result until sum_ready is seen.
module shift_add_product_accumulator #(
    parameter int P_W   = 16,
    parameter int ACC_W = 18,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [P_W-1:0]   prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] SUM_MAX = '1;

    state_t           state;
    logic [LEN_W:0]   count;     // one extra bit so 2^LEN_W products fit
    logic [LEN_W:0]   len_q;     // block length with len=0 mapped to 2^LEN_W
    logic [LEN_W:0]   count_inc;
    logic [ACC_W:0]   sum_ext;   // carry bit flags an unclipped overflow

    assign count_inc = count + 1'b1;
    assign sum_ext   = {1'b0, sum} + {{(ACC_W + 1 - P_W){1'b0}}, prod};

    // Block controller: state, registered handshake outputs, count and saturating sum.
    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sum        <= '0;
            ovf        <= 1'b0;
            count      <= '0;
            len_q      <= '0;
            prod_ready <= 1'b0;
            sum_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // len=0 encodes a full 2^LEN_W block: set the extra MSB.
                        len_q      <= {(len == '0), len};
                        sum        <= '0;
                        ovf        <= 1'b0;
                        count      <= '0;
                        state      <= ACC;
                        prod_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ACC: begin
                    if (prod_valid) begin
                        if (sum_ext[ACC_W]) begin
                            sum <= SUM_MAX;
                            ovf <= 1'b1;
                        end else begin
                            sum <= sum_ext[ACC_W-1:0];
                        end
                        count <= count_inc;
                        if (count_inc == len_q) begin
                            state      <= DONE;
                            prod_ready <= 1'b0;
                            sum_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state     <= IDLE;
                        sum_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    prod_ready <= 1'b0;
                    sum_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
